// File: rtl/iterative_shift_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : iterative_shift_unit_if
// Purpose  : Request/result handshake bundle for the iterative shifter.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface iterative_shift_unit_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [2:0]       in_mode;
   logic [CNT_W-1:0] in_count;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             busy;

   modport master (
      output in_valid, in_data, in_mode, in_count, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, in_mode, in_count, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface
`default_nettype wire

// File: rtl/iterative_shift_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : iterative_shift_unit
// Purpose  : Applies one single-bit shift/rotate step per clock for a
//            latched count, then holds the result under valid/ready.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module iterative_shift_unit #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  wire logic              clk,
   input  wire logic              rst,
   iterative_shift_unit_if.slave  s
);

   localparam logic [2:0]       c_PASS  = 3'b000;
   localparam logic [2:0]       c_SHL0  = 3'b001;
   localparam logic [2:0]       c_SHR0  = 3'b010;
   localparam logic [2:0]       c_SAR   = 3'b011;
   localparam logic [2:0]       c_ROL   = 3'b100;
   localparam logic [2:0]       c_ROR   = 3'b101;
   localparam logic [2:0]       c_SHL1  = 3'b110;
   localparam logic [2:0]       c_SHR1  = 3'b111;
   localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_data;
   logic [2:0]       r_mode;
   logic [CNT_W-1:0] r_cnt;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_busy;
   logic [WIDTH-1:0] w_step;

   function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] v,
                                               input logic [2:0]       m);
      logic [WIDTH-1:0] res;
      res = v;
      case (m)
         c_PASS: res = v;
         c_SHL0: res = {v[WIDTH-2:0], 1'b0};
         c_SHR0: res = {1'b0, v[WIDTH-1:1]};
         c_SAR:  res = {v[WIDTH-1], v[WIDTH-1:1]};
         c_ROL:  res = {v[WIDTH-2:0], v[WIDTH-1]};
         c_ROR:  res = {v[0], v[WIDTH-1:1]};
         c_SHL1: res = {v[WIDTH-2:0], 1'b1};
         c_SHR1: res = {1'b1, v[WIDTH-1:1]};
         default: res = v;
      endcase
      return res;
   endfunction

   assign w_step = f_step(r_data, r_mode);

   // Outputs come straight from registers; the result register is out_data.
   assign s.in_ready  = r_in_ready;
   assign s.out_valid = r_out_valid;
   assign s.out_data  = r_data;
   assign s.busy      = r_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_data      <= '0;
         r_mode      <= c_PASS;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (s.in_valid) begin
                  r_data     <= s.in_data;
                  r_mode     <= s.in_mode;
                  r_cnt      <= s.in_count;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  if (s.in_count == '0) begin
                     r_state     <= DONE;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               // Counts >= WIDTH are stepped literally, no short-cut.
               r_data <= w_step;
               r_cnt  <= r_cnt - c_ONE;
               if (r_cnt == c_ONE) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (s.out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_iterative_shift_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_iterative_shift_unit
// Purpose  : Scoreboard bench for iterative_shift_unit (WIDTH=4, CNT_W=3).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_iterative_shift_unit;

   localparam int c_W = 4;
   localparam int c_C = 3;

   typedef struct {
      logic [c_W-1:0] data;
      int             cnt;
   } exp_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   exp_t sb[$];

   iterative_shift_unit_if #(.WIDTH(c_W), .CNT_W(c_C)) bus ();

   iterative_shift_unit #(.WIDTH(c_W), .CNT_W(c_C)) dut (
      .clk (clk),
      .rst (rst),
      .s   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic t_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Independent arithmetic model of the step table, applied c times.
   function automatic logic [c_W-1:0] ref_shift(input int d, input int m, input int c);
      int v;
      v = d;
      for (int k = 0; k < c; k++) begin
         case (m)
            1: v = (v << 1) & 15;
            2: v = v >> 1;
            3: v = (v >> 1) | (v & 8);
            4: v = ((v << 1) | (v >> 3)) & 15;
            5: v = (v >> 1) | ((v & 1) << 3);
            6: v = ((v << 1) | 1) & 15;
            7: v = (v >> 1) | 8;
            default: v = v;
         endcase
      end
      return v[c_W-1:0];
   endfunction

   task automatic issue(input logic [3:0] d, input logic [2:0] m,
                        input logic [2:0] c, input logic [3:0] e);
      exp_t x;
      int   tries;
      x.data = e;
      x.cnt  = int'(c);
      sb.push_back(x);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_mode  = m;
      bus.in_count = c;
      tries = 0;
      @(negedge clk);
      while (!bus.in_ready && tries < 40) begin
         @(negedge clk);
         tries++;
      end
      t_check("accept_timeout", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      // Post-accept changes must not disturb the latched operation.
      bus.in_data  = ~d;
      bus.in_mode  = ~m;
      bus.in_count = ~c;
   endtask

   task automatic collect(input int hold);
      exp_t e;
      int   cyc;
      t_check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
         e   = sb[0];
         cyc = 0;
         bus.out_ready = (hold == 0);
         while (!bus.out_valid && cyc < 40) begin
            t_check("busy_shift", 32'(bus.busy), 32'd1);
            @(posedge clk);
            #1;
            cyc++;
         end
         t_check("latency", 32'(cyc + 1), 32'(e.cnt + 1));
         t_check("busy_done", 32'(bus.busy), 32'd1);
         for (int h = 0; h < hold; h++) begin
            t_check("bp_valid", 32'(bus.out_valid), 32'd1);
            t_check("bp_data", 32'(bus.out_data), 32'(e.data));
            t_check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
         end
         bus.out_ready = 1'b1;
         t_check("out_valid", 32'(bus.out_valid), 32'd1);
         t_check("out_data", 32'(bus.out_data), 32'(e.data));
         void'(sb.pop_front());
         @(posedge clk);
         #1;
         t_check("gap_in_ready", 32'(bus.in_ready), 32'd1);
         t_check("gap_out_valid", 32'(bus.out_valid), 32'd0);
         t_check("gap_busy", 32'(bus.busy), 32'd0);
         t_check("retain_data", 32'(bus.out_data), 32'(e.data));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int nv;
      logic [3:0] d;
      logic [2:0] m;
      logic [2:0] c;
      n_cmp = 0;
      n_err = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_mode   = '0;
      bus.in_count  = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      t_check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      t_check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      t_check("rst_out_data", 32'(bus.out_data), 32'd0);
      t_check("rst_busy", 32'(bus.busy), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      issue(4'b0101, 3'b001, 3'd1, 4'b1010);  collect(0);
      issue(4'b1010, 3'b011, 3'd2, 4'b1110);  collect(0);
      issue(4'b0011, 3'b101, 3'd5, 4'b1001);  collect(0);
      issue(4'b0110, 3'b111, 3'd0, 4'b0110);  collect(0);
      issue(4'b0010, 3'b110, 3'd3, 4'b0111);  collect(0);

      // Backpressure with a second request already waiting upstream.
      issue(4'b0101, 3'b001, 3'd1, 4'b1010);
      bus.in_valid = 1'b1;
      bus.in_data  = 4'b1111;
      bus.in_mode  = 3'b010;
      bus.in_count = 3'd1;
      collect(3);
      issue(4'b1111, 3'b010, 3'd1, 4'b0111);  collect(0);

      for (int i = 0; i < 20; i++) begin
         d = 4'($urandom_range(0, 15));
         m = 3'($urandom_range(0, 7));
         c = 3'($urandom_range(0, 7));
         issue(d, m, c, ref_shift(int'(d), int'(m), int'(c)));
         collect(int'($urandom_range(0, 2)));
      end

      // Abort mid-shift: the pending result is discarded.
      issue(4'b1100, 3'b100, 3'd6, 4'b0011);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      t_check("abort_in_ready", 32'(bus.in_ready), 32'd1);
      t_check("abort_out_valid", 32'(bus.out_valid), 32'd0);
      t_check("abort_out_data", 32'(bus.out_data), 32'd0);
      t_check("abort_busy", 32'(bus.busy), 32'd0);
      nv = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) nv++;
      end
      t_check("abort_no_result", 32'(nv), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
